wb_regfile_write_scheduler: RTL and testbench

Sits between the write-back stage and the register file's single write port. Each write-back beat can carry a general-register write plus an R7 (PC) write, so the block queues up to two write entries per beat. It drains them in order, one per granted cycle, and gives decode a lookup port so it can forward data that is queued but not yet written.

---
 rtl/wb_regfile_write_scheduler.sv | 112 +++++++++++
 tb/tb_wb_regfile_write_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile_write_scheduler.sv
// Write-back to register-file write scheduler: queues up to two writes per beat, drains one per grant.
// Optional decode forwarding lookup is built only when WB_SCHED_FWD_EN is defined.
module wb_regfile_write_scheduler #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wbValid,
   output logic             wbReady,
   input  logic             regWriteEn,
   input  logic [2:0]       regAddr,
   input  logic [15:0]      writeData,
   input  logic             r7WriteEn,
   input  logic [15:0]      writeR7Data,
   output logic             rfWrEn,
   output logic [2:0]       rfWrAddr,
   output logic [15:0]      rfWrData,
   input  logic             rfGrant,
   input  logic [2:0]       lookupAddr,
   output logic             lookupHit,
   output logic [15:0]      lookupData,
   output logic [PTR_W:0]   pendCount,
   output logic             empty
);

   localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);

   logic [2:0]       addr_q [DEPTH];
   logic [15:0]      data_q [DEPTH];
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] wrPtrNext1;
   logic [PTR_W:0]   cnt;
   logic [PTR_W:0]   numGen;
   logic [PTR_W:0]   cntNext;
   logic             accept;
   logic             genA;
   logic             genB;
   logic             pop;

   // Handshake: a beat transfers on a rising edge where wbValid && wbReady; wbReady
   // comes from registered state only, so the producer may hold wbValid until it sees it.
   // A queued write retires on a rising edge where rfWrEn && rfGrant; the head is held otherwise.
   assign wbReady    = (cnt <= READY_MAX);
   assign accept     = wbValid && wbReady;
   assign genA       = regWriteEn && !(r7WriteEn && (regAddr == 3'd7));
   assign genB       = r7WriteEn;
   assign numGen     = (PTR_W+1)'(genA) + (PTR_W+1)'(genB);
   assign wrPtrNext1 = wrPtr + PTR_W'(1);

   assign rfWrEn   = (cnt != '0);
   assign rfWrAddr = rfWrEn ? addr_q[rdPtr] : 3'd0;
   assign rfWrData = rfWrEn ? data_q[rdPtr] : 16'd0;
   assign pop      = rfWrEn && rfGrant;

   assign cntNext   = cnt + (accept ? numGen : '0) - (PTR_W+1)'(pop);
   assign pendCount = cnt;
   assign empty     = (cnt == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         cnt   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= 3'd0;
            data_q[i] <= 16'd0;
         end
      end else begin
         if (accept && genA) begin
            addr_q[wrPtr] <= regAddr;
            data_q[wrPtr] <= writeData;
         end
         // R7 lands behind the general write when both are present in one beat.
         if (accept && genB) begin
            addr_q[genA ? wrPtrNext1 : wrPtr] <= 3'd7;
            data_q[genA ? wrPtrNext1 : wrPtr] <= writeR7Data;
         end
         if (accept)
            wrPtr <= wrPtr + numGen[PTR_W-1:0];
         if (pop)
            rdPtr <= rdPtr + PTR_W'(1);
         cnt <= cntNext;
      end
   end

`ifdef WB_SCHED_FWD_EN
   logic [PTR_W-1:0] scanIdx;

   // Scan oldest to youngest so a later match overrides an earlier one.
   always_comb begin
      lookupHit  = 1'b0;
      lookupData = 16'd0;
      scanIdx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         scanIdx = rdPtr + PTR_W'(i);
         if (((PTR_W+1)'(i) < cnt) && (addr_q[scanIdx] == lookupAddr)) begin
            lookupHit  = 1'b1;
            lookupData = data_q[scanIdx];
         end
      end
   end
`else
   logic unused_lookup;

   assign unused_lookup = ^lookupAddr;
   assign lookupHit     = 1'b0;
   assign lookupData    = 16'd0;
`endif

endmodule

// File: tb/tb_wb_regfile_write_scheduler.sv
// Directed self-checking bench for wb_regfile_write_scheduler (DEPTH=4).
module tb_wb_regfile_write_scheduler;

   logic        clk;
   logic        rst_n;
   logic        wbValid;
   logic        wbReady;
   logic        regWriteEn;
   logic [2:0]  regAddr;
   logic [15:0] writeData;
   logic        r7WriteEn;
   logic [15:0] writeR7Data;
   logic        rfWrEn;
   logic [2:0]  rfWrAddr;
   logic [15:0] rfWrData;
   logic        rfGrant;
   logic [2:0]  lookupAddr;
   logic        lookupHit;
   logic [15:0] lookupData;
   logic [2:0]  pendCount;
   logic        empty;

   int n_cmp = 0;
   int n_err = 0;
   logic [18:0] exp_q[$];

   wb_regfile_write_scheduler #(.DEPTH(4), .PTR_W(2)) dut (
      .clk(clk), .reset(rst_n),
      .wbValid(wbValid), .wbReady(wbReady),
      .regWriteEn(regWriteEn), .regAddr(regAddr), .writeData(writeData),
      .r7WriteEn(r7WriteEn), .writeR7Data(writeR7Data),
      .rfWrEn(rfWrEn), .rfWrAddr(rfWrAddr), .rfWrData(rfWrData), .rfGrant(rfGrant),
      .lookupAddr(lookupAddr), .lookupHit(lookupHit), .lookupData(lookupData),
      .pendCount(pendCount), .empty(empty)
   );

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic set_beat(input logic v, input logic re, input logic [2:0] ra,
                           input logic [15:0] wd, input logic r7e, input logic [15:0] r7d);
      wbValid     = v;
      regWriteEn  = re;
      regAddr     = ra;
      writeData   = wd;
      r7WriteEn   = r7e;
      writeR7Data = r7d;
   endtask

   task automatic set_idle();
      set_beat(1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 16'd0);
   endtask

   // Scoreboard: grant every presented write and compare it against the expected queue.
   task automatic drain_scoreboard(input string name);
      rfGrant = 1'b1;
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
         if (rfWrEn) begin
            logic [18:0] e;
            e = exp_q.pop_front();
            n_cmp++;
            if ({rfWrAddr, rfWrData} !== e) begin
               n_err++;
               $display("FAIL %s_order: got addr=%0d data=%h expected addr=%0d data=%h",
                        name, rfWrAddr, rfWrData, e[18:16], e[15:0]);
            end
         end
         @(negedge clk);
      end
      n_cmp++;
      if (exp_q.size() != 0 || rfWrEn !== 1'b0 || empty !== 1'b1) begin
         n_err++;
         $display("FAIL %s_drained: left=%0d rfWrEn=%b empty=%b expected left=0 rfWrEn=0 empty=1",
                  name, exp_q.size(), rfWrEn, empty);
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rfGrant = 1'b0;
      lookupAddr = 3'd0;
      set_idle();
      #12;
      n_cmp++;
      if ({rfWrEn, rfWrAddr, rfWrData, wbReady, lookupHit, lookupData, pendCount, empty}
          !== {1'b0, 3'd0, 16'd0, 1'b1, 1'b0, 16'd0, 3'd0, 1'b1}) begin
         n_err++;
         $display("FAIL reset_state: rfWrEn=%b addr=%0d data=%h ready=%b hit=%b ldata=%h cnt=%0d empty=%b expected 0,0,0000,1,0,0000,0,1",
                  rfWrEn, rfWrAddr, rfWrData, wbReady, lookupHit, lookupData, pendCount, empty);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_dual_write();
      @(negedge clk);
      rfGrant = 1'b1;
      set_beat(1'b1, 1'b1, 3'd3, 16'h1234, 1'b1, 16'h0040);
      @(negedge clk);
      set_idle();
      n_cmp++;
      if ({pendCount, rfWrEn, rfWrAddr, rfWrData} !== {3'd2, 1'b1, 3'd3, 16'h1234}) begin
         n_err++;
         $display("FAIL dual_first: cnt=%0d en=%b addr=%0d data=%h expected 2,1,3,1234",
                  pendCount, rfWrEn, rfWrAddr, rfWrData);
      end
      @(negedge clk);
      n_cmp++;
      if ({pendCount, rfWrEn, rfWrAddr, rfWrData} !== {3'd1, 1'b1, 3'd7, 16'h0040}) begin
         n_err++;
         $display("FAIL dual_second: cnt=%0d en=%b addr=%0d data=%h expected 1,1,7,0040",
                  pendCount, rfWrEn, rfWrAddr, rfWrData);
      end
      @(negedge clk);
      n_cmp++;
      if ({pendCount, rfWrEn, empty, rfWrAddr, rfWrData} !== {3'd0, 1'b0, 1'b1, 3'd0, 16'd0}) begin
         n_err++;
         $display("FAIL dual_done: cnt=%0d en=%b empty=%b addr=%0d data=%h expected 0,0,1,0,0000",
                  pendCount, rfWrEn, empty, rfWrAddr, rfWrData);
      end
   endtask

   task automatic test_collision();
      rfGrant = 1'b1;
      set_beat(1'b1, 1'b1, 3'd7, 16'hAAAA, 1'b1, 16'h5555);
      @(negedge clk);
      set_idle();
      n_cmp++;
      if ({pendCount, rfWrEn, rfWrAddr, rfWrData} !== {3'd1, 1'b1, 3'd7, 16'h5555}) begin
         n_err++;
         $display("FAIL collision_write: cnt=%0d en=%b addr=%0d data=%h expected 1,1,7,5555",
                  pendCount, rfWrEn, rfWrAddr, rfWrData);
      end
      @(negedge clk);
      n_cmp++;
      if ({pendCount, rfWrEn} !== {3'd0, 1'b0}) begin
         n_err++;
         $display("FAIL collision_single: cnt=%0d en=%b expected 0,0", pendCount, rfWrEn);
      end
   endtask

   task automatic test_no_write_and_single();
      rfGrant = 1'b1;
      set_beat(1'b1, 1'b0, 3'd4, 16'hDEAD, 1'b0, 16'hBEEF);
      @(negedge clk);
      n_cmp++;
      if ({pendCount, rfWrEn, empty} !== {3'd0, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL no_write_beat: cnt=%0d en=%b empty=%b expected 0,0,1", pendCount, rfWrEn, empty);
      end
      set_beat(1'b1, 1'b1, 3'd7, 16'hBEEF, 1'b0, 16'h0000);
      exp_q.push_back({3'd7, 16'hBEEF});
      @(negedge clk);
      set_idle();
      n_cmp++;
      if (pendCount !== 3'd1) begin
         n_err++;
         $display("FAIL single_reg7_cnt: cnt=%0d expected 1", pendCount);
      end
      drain_scoreboard("single_reg7");
   endtask

   task automatic test_back_pressure();
      rfGrant = 1'b0;
      set_beat(1'b1, 1'b1, 3'd1, 16'h1001, 1'b1, 16'h7001);
      exp_q.push_back({3'd1, 16'h1001});
      exp_q.push_back({3'd7, 16'h7001});
      @(negedge clk);
      n_cmp++;
      if ({pendCount, wbReady} !== {3'd2, 1'b1}) begin
         n_err++;
         $display("FAIL bp_cnt2: cnt=%0d ready=%b expected 2,1", pendCount, wbReady);
      end
      set_beat(1'b1, 1'b1, 3'd2, 16'h1002, 1'b1, 16'h7002);
      exp_q.push_back({3'd2, 16'h1002});
      exp_q.push_back({3'd7, 16'h7002});
      @(negedge clk);
      set_beat(1'b1, 1'b1, 3'd3, 16'h1003, 1'b1, 16'h7003);
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if ({pendCount, wbReady, rfWrEn, rfWrAddr, rfWrData} !== {3'd4, 1'b0, 1'b1, 3'd1, 16'h1001}) begin
            n_err++;
            $display("FAIL bp_hold%0d: cnt=%0d ready=%b en=%b addr=%0d data=%h expected 4,0,1,1,1001",
                     k, pendCount, wbReady, rfWrEn, rfWrAddr, rfWrData);
         end
         @(negedge clk);
      end
      set_idle();
      drain_scoreboard("bp");
   endtask

   task automatic test_accept_pop();
      rfGrant = 1'b0;
      set_beat(1'b1, 1'b1, 3'd4, 16'h4444, 1'b1, 16'h7777);
      @(negedge clk);
      n_cmp++;
      if ({pendCount, wbReady, rfWrAddr, rfWrData} !== {3'd2, 1'b1, 3'd4, 16'h4444}) begin
         n_err++;
         $display("FAIL ap_before: cnt=%0d ready=%b addr=%0d data=%h expected 2,1,4,4444",
                  pendCount, wbReady, rfWrAddr, rfWrData);
      end
      rfGrant = 1'b1;
      set_beat(1'b1, 1'b1, 3'd5, 16'h5555, 1'b1, 16'h7555);
      @(negedge clk);
      set_idle();
      n_cmp++;
      if ({pendCount, wbReady, rfWrAddr, rfWrData} !== {3'd3, 1'b0, 3'd7, 16'h7777}) begin
         n_err++;
         $display("FAIL ap_after: cnt=%0d ready=%b addr=%0d data=%h expected 3,0,7,7777",
                  pendCount, wbReady, rfWrAddr, rfWrData);
      end
      exp_q.push_back({3'd7, 16'h7777});
      exp_q.push_back({3'd5, 16'h5555});
      exp_q.push_back({3'd7, 16'h7555});
      drain_scoreboard("ap");
   endtask

   task automatic test_forward();
      rfGrant = 1'b0;
      lookupAddr = 3'd2;
      set_beat(1'b1, 1'b1, 3'd2, 16'h0001, 1'b0, 16'h0000);
      @(negedge clk);
      set_beat(1'b1, 1'b1, 3'd2, 16'h0002, 1'b0, 16'h0000);
      n_cmp++;
`ifdef WB_SCHED_FWD_EN
      if ({lookupHit, lookupData} !== {1'b1, 16'h0001}) begin
`else
      if ({lookupHit, lookupData} !== {1'b0, 16'h0000}) begin
`endif
         n_err++;
         $display("FAIL fwd_one: hit=%b data=%h", lookupHit, lookupData);
      end
      @(negedge clk);
      set_idle();
      n_cmp++;
`ifdef WB_SCHED_FWD_EN
      if ({lookupHit, lookupData} !== {1'b1, 16'h0002}) begin
`else
      if ({lookupHit, lookupData} !== {1'b0, 16'h0000}) begin
`endif
         n_err++;
         $display("FAIL fwd_youngest: hit=%b data=%h", lookupHit, lookupData);
      end
      lookupAddr = 3'd5;
      #1;
      n_cmp++;
      if ({lookupHit, lookupData} !== {1'b0, 16'h0000}) begin
         n_err++;
         $display("FAIL fwd_miss: hit=%b data=%h expected 0,0000", lookupHit, lookupData);
      end
      lookupAddr = 3'd0;
      exp_q.push_back({3'd2, 16'h0001});
      exp_q.push_back({3'd2, 16'h0002});
      drain_scoreboard("fwd");
   endtask

   task automatic test_reset_midqueue();
      rfGrant = 1'b0;
      set_beat(1'b1, 1'b1, 3'd1, 16'h0A01, 1'b1, 16'h0A07);
      @(negedge clk);
      set_beat(1'b1, 1'b1, 3'd6, 16'h0A06, 1'b0, 16'h0000);
      @(negedge clk);
      set_idle();
      n_cmp++;
      if (pendCount !== 3'd3) begin
         n_err++;
         $display("FAIL midq_cnt3: cnt=%0d expected 3", pendCount);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({pendCount, rfWrEn, wbReady, empty} !== {3'd0, 1'b0, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL midq_async: cnt=%0d en=%b ready=%b empty=%b expected 0,0,1,1",
                  pendCount, rfWrEn, wbReady, empty);
      end
      @(negedge clk);
      rst_n = 1'b1;
      rfGrant = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if (rfWrEn !== 1'b0) begin
            n_err++;
            $display("FAIL midq_quiet%0d: rfWrEn=%b expected 0", k, rfWrEn);
         end
      end
   endtask

   initial begin
      test_reset();
      test_dual_write();
      test_collision();
      test_no_write_and_single();
      test_back_pressure();
      test_accept_pop();
      test_forward();
      test_reset_midqueue();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
